// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizer, frame deframer/checker, show-ahead byte FIFO.
// Optional partial-frame idle timeout enabled by defining PS2_TIMEOUT_EN.
module ps2_kbd_rx #(
   parameter int FIFO_AW     = 3,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       rd_en,
   input  logic       ovf_clr,
   output logic [7:0] data,
   output logic       valid,
   output logic       overflow,
   output logic       frame_err
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0] PTR_ONE = 1;

   if (FIFO_AW < 1 || TIMEOUT_CYC < 2) begin : g_bad_param
      $error("ps2_kbd_rx: bad parameter");
   end

   logic clk_s1, clk_s2, clk_s3;
   logic dat_s1, dat_s2;
   logic fall, fall_q, bit_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         clk_s3 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
         fall_q <= 1'b0;
         bit_q  <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         clk_s3 <= clk_s2;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
         fall_q <= fall;
         bit_q  <= dat_s2;
      end
   end

   assign fall = clk_s3 & ~clk_s2;

   logic [3:0] cnt;
   logic [9:0] sr;
   logic       good;
   logic       push_q;
   logic [7:0] push_byte;

   // sr[0]=start, sr[8:1]=d0..d7, sr[9]=parity; bit_q is the stop bit
   assign good = ~sr[0] & bit_q & (^sr[9:1]);

`ifdef PS2_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC);
   logic [TW-1:0] idle;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         sr        <= '0;
         push_q    <= 1'b0;
         push_byte <= '0;
         frame_err <= 1'b0;
`ifdef PS2_TIMEOUT_EN
         idle      <= '0;
`endif
      end else begin
         push_q    <= 1'b0;
         frame_err <= 1'b0;
         if (fall_q) begin
`ifdef PS2_TIMEOUT_EN
            idle <= '0;
`endif
            if (cnt == 4'd10) begin
               cnt <= '0;
               if (good) begin
                  push_q    <= 1'b1;
                  push_byte <= sr[8:1];
               end else begin
                  frame_err <= 1'b1;
               end
            end else if (!(cnt == 4'd0 && bit_q)) begin
               sr  <= {bit_q, sr[9:1]};
               cnt <= cnt + 4'd1;
            end
         end
`ifdef PS2_TIMEOUT_EN
         else if (cnt != 4'd0) begin
            if (idle == TW'(TIMEOUT_CYC - 1)) begin
               cnt       <= '0;
               idle      <= '0;
               frame_err <= 1'b1;
            end else begin
               idle <= idle + TW'(1);
            end
         end
`endif
      end
   end

   logic [7:0]       mem [DEPTH];
   logic [FIFO_AW:0] wr_ptr, rd_ptr;
   logic             empty, full, pop, wr_ok;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                  (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   assign pop   = rd_en & ~empty;
   // a pop in the same cycle frees the slot for a push into a full FIFO
   assign wr_ok = push_q & (~full | pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_ok) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= push_byte;
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_ONE;
         if (push_q && !wr_ok) overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   assign data  = mem[rd_ptr[FIFO_AW-1:0]];
   assign valid = ~empty;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: frames, errors, FIFO order/overflow, reset, timeout.
module tb_ps2_kbd_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rd_en = 1'b0;
   logic       ovf_clr = 1'b0;
   logic [7:0] data;
   logic       valid, overflow, frame_err;

   int n_assert = 0;
   int n_fail = 0;

   ps2_kbd_rx #(.FIFO_AW(3), .TIMEOUT_CYC(200)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .rd_en(rd_en), .ovf_clr(ovf_clr), .data(data), .valid(valid),
      .overflow(overflow), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic ps2_bit(input logic b);
      @(negedge clk) ps2_data = b;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (8) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // start, 8 data bits LSB first, parity (odd unless bad), stop
   function automatic logic [10:0] frame(input logic [7:0] b, input logic bad);
      logic p;
      p = ~(^b) ^ bad;
      return {1'b1, p, b, 1'b0};
   endfunction

   task automatic send_head(input logic [7:0] b, input logic bad);
      logic [10:0] f;
      f = frame(b, bad);
      for (int i = 0; i < 10; i++) ps2_bit(f[i]);
   endtask

   // leaves the final ps2_clk low just set at a negedge
   task automatic last_fall();
      @(negedge clk) ps2_data = 1'b1;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b0;
   endtask

   task automatic tail();
      repeat (8) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b, input logic bad);
      send_head(b, bad);
      last_fall();
      tail();
   endtask

   task automatic pop();
      @(negedge clk) rd_en = 1'b1;
      @(negedge clk) rd_en = 1'b0;
   endtask

   initial begin
      // reset
      repeat (3) @(negedge clk);
      chk("rst_valid", 8'(valid), 8'h0);
      chk("rst_data", data, 8'h00);
      chk("rst_ovf", 8'(overflow), 8'h0);
      chk("rst_ferr", 8'(frame_err), 8'h0);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // 1: single frame with exact latency
      send_head(8'h1C, 1'b0);
      last_fall();
      repeat (4) @(posedge clk);
      #1 chk("t1_valid_p3", 8'(valid), 8'h0);
      @(posedge clk);
      #1 chk("t1_valid_p4", 8'(valid), 8'h1);
      chk("t1_data", data, 8'h1C);
      chk("t1_ferr", 8'(frame_err), 8'h0);
      tail();
      pop();
      chk("t1_pop_valid", 8'(valid), 8'h0);

      // 2: two frames, show-ahead order
      send(8'hF0, 1'b0);
      send(8'h1C, 1'b0);
      chk("t2_head0", data, 8'hF0);
      pop();
      chk("t2_head1", data, 8'h1C);
      chk("t2_valid1", 8'(valid), 8'h1);
      pop();
      chk("t2_empty", 8'(valid), 8'h0);
      pop();
      chk("t2_pop_empty", 8'(valid), 8'h0);

      // 3: parity error pulse is exactly one cycle
      send_head(8'h1C, 1'b1);
      last_fall();
      repeat (3) @(posedge clk);
      #1 chk("t3_ferr_p2", 8'(frame_err), 8'h0);
      @(posedge clk);
      #1 chk("t3_ferr_p3", 8'(frame_err), 8'h1);
      @(posedge clk);
      #1 chk("t3_ferr_p4", 8'(frame_err), 8'h0);
      tail();
      chk("t3_valid", 8'(valid), 8'h0);
      send(8'h1C, 1'b0);
      chk("t3_next_valid", 8'(valid), 8'h1);
      chk("t3_next_data", data, 8'h1C);
      pop();

      // 4: overflow on ninth frame
      for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
      chk("t4_no_ovf", 8'(overflow), 8'h0);
      send(8'h09, 1'b0);
      chk("t4_ovf", 8'(overflow), 8'h1);
      chk("t4_head", data, 8'h01);
      for (int i = 1; i <= 8; i++) begin
         chk("t4_order", data, 8'(i));
         pop();
      end
      chk("t4_empty", 8'(valid), 8'h0);
      chk("t4_ovf_sticky", 8'(overflow), 8'h1);
      @(negedge clk) ovf_clr = 1'b1;
      @(negedge clk) ovf_clr = 1'b0;
      chk("t4_ovf_clr", 8'(overflow), 8'h0);

      // 5: push into full FIFO with simultaneous pop
      for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
      send_head(8'h09, 1'b0);
      last_fall();
      repeat (4) @(posedge clk);
      #1 rd_en = 1'b1;
      @(posedge clk);
      #1 rd_en = 1'b0;
      chk("t5_no_ovf", 8'(overflow), 8'h0);
      tail();
      for (int i = 2; i <= 9; i++) begin
         chk("t5_order", data, 8'(i));
         pop();
      end
      chk("t5_empty", 8'(valid), 8'h0);

      // 6: reset mid-frame
      for (int i = 0; i < 5; i++) ps2_bit(frame(8'h1C, 1'b0)[i]);
      @(negedge clk) rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      chk("t6_rst_valid", 8'(valid), 8'h0);
      send(8'h1C, 1'b0);
      chk("t6_valid", 8'(valid), 8'h1);
      chk("t6_data", data, 8'h1C);
      pop();
      chk("t6_empty", 8'(valid), 8'h0);

`ifdef PS2_TIMEOUT_EN
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 5; i++) ps2_bit(frame(8'hF0, 1'b0)[i]);
         for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (frame_err) seen++;
         end
         chk("t6_timeout_pulses", 8'(seen), 8'h1);
         chk("t6_timeout_valid", 8'(valid), 8'h0);
         send(8'h1C, 1'b0);
         chk("t6_after_to_data", data, 8'h1C);
         chk("t6_after_to_valid", 8'(valid), 8'h1);
         pop();
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
